// File: rtl/game_display_animator.sv
// game_display_animator
//   Registered seven-segment and LED-bar driver for the Rock-Paper-Scissors-
//   Lizard-Spock game. It shows the win/loss score, the FPGA's choice word and
//   the result word. A built-in prescaler paces the win scroll and the loss
//   blink. anim_done pulses for one cycle when a result animation finishes
//   and the display settles into hold.
//
//   Timing: the mode/result key is compared live against its registered copy.
//   A change therefore steers the next-state and output logic in the same
//   cycle, and every registered output reflects new inputs one edge later.

module game_display_animator #(
  parameter int NUM_LEDS      = 10,
  parameter int TICK_DIV      = 2500000,
  parameter int SCROLL_PASSES = 2,
  parameter int BLINK_COUNT   = 3
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [1:0]          mode,
  input  logic [2:0]          choice,
  input  logic [1:0]          result,
  input  logic [6:0]          wins,
  input  logic [6:0]          losses,
  output logic [NUM_LEDS-1:0] LED,
  output logic [7:0]          h0,
  output logic [7:0]          h1,
  output logic [7:0]          h2,
  output logic [7:0]          h3,
  output logic [7:0]          h4,
  output logic [7:0]          h5,
  output logic                anim_done
);

  // ---------------------------------------------------------------------------
  // Counter widths
  // ---------------------------------------------------------------------------
  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int POS_W   = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;
  // The pass counter holds the number of completed sweeps, 0..SCROLL_PASSES-1.
  localparam int PASS_W  = (SCROLL_PASSES > 2) ? $clog2(SCROLL_PASSES) : 1;
  // The blink counter holds the number of elapsed ticks, 0..2*BLINK_COUNT-1.
  localparam int BLINK_W = (BLINK_COUNT > 1) ? $clog2(2 * BLINK_COUNT) : 1;

  localparam logic [NUM_LEDS-1:0] LED_ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] LED_MSB = {1'b1, {(NUM_LEDS-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Display words, packed as {h5,h4,h3,h2,h1,h0}
  // ---------------------------------------------------------------------------
  localparam logic [47:0] WORD_ROCK    = 48'h00_00_31_3F_39_39;
  localparam logic [47:0] WORD_PAPER   = 48'h00_73_77_73_79_31;
  localparam logic [47:0] WORD_SCISSOR = 48'h6D_39_06_6D_3F_31;
  localparam logic [47:0] WORD_LIZARD  = 48'h38_06_6D_77_31_5E;
  localparam logic [47:0] WORD_SPOCK   = 48'h00_6D_73_3F_39_39;
  localparam logic [47:0] WORD_INVALID = 48'h40_40_40_40_40_40;
  localparam logic [47:0] WORD_WIN     = 48'h00_00_3E_3E_06_37;
  localparam logic [47:0] WORD_LOSS    = 48'h00_00_38_3F_6D_79;
  localparam logic [47:0] WORD_TIE     = 48'h00_00_00_78_06_79;

  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHOICE,
    S_WIN,
    S_LOSS,
    S_TIE,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] digit_glyph(input int d);
    case (d)
      0:       digit_glyph = 8'h3F;
      1:       digit_glyph = 8'h06;
      2:       digit_glyph = 8'h5B;
      3:       digit_glyph = 8'h4F;
      4:       digit_glyph = 8'h66;
      5:       digit_glyph = 8'h6D;
      6:       digit_glyph = 8'h7D;
      7:       digit_glyph = 8'h07;
      8:       digit_glyph = 8'h7F;
      9:       digit_glyph = 8'h6F;
      default: digit_glyph = GLYPH_BLANK;
    endcase
  endfunction

  // Two-digit score {tens, ones}: saturates at 99 and blanks a leading zero.
  function automatic logic [15:0] score_pair(input logic [6:0] v);
    int n;
    n = (v > 7'd99) ? 99 : int'(v);
    score_pair = {(n < 10) ? GLYPH_BLANK : digit_glyph(n / 10), digit_glyph(n % 10)};
  endfunction

  function automatic logic [47:0] choice_word(input logic [2:0] c);
    case (c)
      3'd0:    choice_word = WORD_ROCK;
      3'd1:    choice_word = WORD_PAPER;
      3'd2:    choice_word = WORD_SCISSOR;
      3'd3:    choice_word = WORD_LIZARD;
      3'd4:    choice_word = WORD_SPOCK;
      default: choice_word = WORD_INVALID;
    endcase
  endfunction

  // State that a freshly changed key enters.
  function automatic state_t entry_state(input logic [3:0] key);
    case (key[3:2])
      2'd1:    entry_state = S_CHOICE;
      2'd2: begin
        case (key[1:0])
          2'd1:    entry_state = S_WIN;
          2'd2:    entry_state = S_LOSS;
          default: entry_state = S_TIE;
        endcase
      end
      default: entry_state = S_IDLE;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [3:0]           key_q, key_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [PASS_W-1:0]    pass_q, pass_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic [47:0]          h_q, h_d;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic                 anim_done_q, anim_done_d;

  logic [1:0]           mode_eff;
  logic                 key_change;
  logic                 tick;

  // Normalise the key: mode 3 behaves as mode 0, and result matters only in mode 2.
  always_comb begin
    mode_eff   = (mode == 2'd3) ? 2'd0 : mode;
    key_d      = {mode_eff, (mode_eff == 2'd2) ? result : 2'd0};
    key_change = (key_d != key_q);
    tick       = (presc_q == PRESC_W'(TICK_DIV - 1));
  end

  // State, counter and output registers; everything clears on reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      presc_q     <= '0;
      pos_q       <= '0;
      pass_q      <= '0;
      blink_q     <= '0;
      h_q         <= '0;
      led_q       <= '0;
      anim_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values from
      // before the edge. Blocking assignments here would chain the registers into
      // one cycle.
      state_q     <= state_d;
      key_q       <= key_d;
      presc_q     <= presc_d;
      pos_q       <= pos_d;
      pass_q      <= pass_d;
      blink_q     <= blink_d;
      h_q         <= h_d;
      led_q       <= led_d;
      anim_done_q <= anim_done_d;
    end
  end

  // Next-state logic: a key change restarts from entry values; otherwise animations advance on ticks.
  always_comb begin
    // NOTE: every comb output gets a default first. A path that leaves one
    // unassigned would otherwise infer a latch.
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    pos_d   = pos_q;
    pass_d  = pass_q;
    blink_d = blink_q;

    if (key_change) begin
      state_d = entry_state(key_d);
      presc_d = '0;
      pos_d   = POS_W'(NUM_LEDS - 1);
      pass_d  = '0;
      blink_d = '0;
    end else begin
      case (state_q)
        S_WIN: begin
          if (tick) begin
            if (pos_q == '0) begin
              pos_d = POS_W'(NUM_LEDS - 1);
              if (pass_q == PASS_W'(SCROLL_PASSES - 1)) begin
                state_d = S_HOLD;
              end else begin
                pass_d = pass_q + PASS_W'(1);
              end
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        S_LOSS: begin
          if (tick) begin
            if (blink_q == BLINK_W'(2 * BLINK_COUNT - 1)) begin
              state_d = S_HOLD;
            end else begin
              blink_d = blink_q + BLINK_W'(1);
            end
          end
        end
        S_TIE: begin
          if (tick) begin
            state_d = S_HOLD;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: derive the next display and LED from the next state; hold freezes them.
  always_comb begin
    h_d         = h_q;
    led_d       = led_q;
    anim_done_d = 1'b0;

    if ((state_q != S_HOLD) && (state_d == S_HOLD)) begin
      // An animation finishes. The result word is already on display; only the LED bar settles.
      anim_done_d = 1'b1;
      led_d       = (state_q == S_WIN) ? '1 : '0;
    end else begin
      case (state_d)
        S_IDLE: begin
          h_d   = {score_pair(wins), GLYPH_DASH, GLYPH_BLANK, score_pair(losses)};
          led_d = '0;
        end
        S_CHOICE: begin
          h_d   = choice_word(choice);
          led_d = LED_MSB;
        end
        S_WIN: begin
          h_d   = WORD_WIN;
          led_d = LED_ONE << pos_d;
        end
        S_LOSS: begin
          // An even tick count shows the bar lit and an odd count shows it dark.
          h_d   = WORD_LOSS;
          led_d = blink_d[0] ? '0 : '1;
        end
        S_TIE: begin
          h_d   = WORD_TIE;
          led_d = '0;
        end
        default: ;
      endcase
    end
  end

  assign h5        = h_q[47:40];
  assign h4        = h_q[39:32];
  assign h3        = h_q[31:24];
  assign h2        = h_q[23:16];
  assign h1        = h_q[15:8];
  assign h0        = h_q[7:0];
  assign LED       = led_q;
  assign anim_done = anim_done_q;

endmodule
